// File: rtl/simd_ctrl_pkg.sv
// simd_ctrl_pkg: shared definitions for the simd sequencing controller.
// Holds the opcode and FSM state encodings plus the default datapath
// latency and tag width that the controller shares with the simd datapath.
package simd_ctrl_pkg;

  // Default datapath latency (dp_start to valid lane results) and tag width.
  localparam int DEF_LAT  = 2;
  localparam int DEF_TAGW = 4;

  // Datapath opcodes as seen on dp_op.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Plain-vector copies of the state encoding for the state register.
  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_ISSUE = S_ISSUE;
  localparam logic [1:0] ST_WAIT  = S_WAIT;
  localparam logic [1:0] ST_RESP  = S_RESP;

endpackage

// File: rtl/simd_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, purely combinational.
// Ports:
//   valid[1:0] in  : request valids (bit N = requester N)
//   last       in  : requester granted most recently
//   en         in  : arbitration enable; no grant when low
//   grant[1:0] out : one-hot grant (all zero when nothing to grant)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

  // Grant the requester that did not win last time when both are asking.
  always_comb begin
    grant = 2'b00;
    if (!en) begin
      grant = 2'b00;
    end else if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/simd_ctrl.sv
// simd_ctrl: sequencing and arbitration controller for the 4-lane simd
// datapath. Two requesters (0: host, 1: DMA) are granted round-robin; one
// operation is in flight at a time: ISSUE pulses dp_start, WAIT counts the
// datapath latency and pulses dp_capture, RESP holds a tagged response
// until rsp_ready.
// Ports:
//   clk, rst (async active-low), enable (gates new grants only)
//   req0_*/req1_* : valid/op/tag in, ready out (ready is combinational)
//   dp_start, dp_capture : one-cycle datapath strobes
//   dp_op, dp_sel : opcode and operand bank, held from ISSUE through RESP
//   rsp_valid/rsp_src/rsp_tag out, rsp_ready in : response channel
//   busy : not IDLE;  ops_done : completed operations, wraps at 256
module simd_ctrl
  import simd_ctrl_pkg::*;
#(
  parameter int LAT  = DEF_LAT,
  parameter int TAGW = DEF_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            req0_valid,
  input  logic [1:0]      req0_op,
  input  logic [TAGW-1:0] req0_tag,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [1:0]      req1_op,
  input  logic [TAGW-1:0] req1_tag,
  output logic            req1_ready,
  output logic            dp_start,
  output logic [1:0]      dp_op,
  output logic            dp_sel,
  output logic            dp_capture,
  output logic            rsp_valid,
  output logic            rsp_src,
  output logic [TAGW-1:0] rsp_tag,
  input  logic            rsp_ready,
  output logic            busy,
  output logic [7:0]      ops_done
);

  // Counter wide enough for LAT-1; at least one bit so LAT=1 still works.
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [1:0]      state_r;
  logic [CNTW-1:0] cnt_r;
  logic            last_r;
  op_e             op_r;
  logic            sel_r;
  logic [TAGW-1:0] tag_r;
  logic [7:0]      ops_r;

  logic [1:0]      grant_s;
  logic            idle_s;
  logic            req_hs_s;
  logic            hs_src_s;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last_r),
    .en    (enable),
    .grant (grant_s)
  );

  assign idle_s     = (state_r == ST_IDLE);
  assign req0_ready = idle_s & grant_s[0];
  assign req1_ready = idle_s & grant_s[1];
  assign req_hs_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  // The grant is one-hot, so bit 1 alone identifies the winning source.
  assign hs_src_s   = grant_s[1];

  // FSM, operand latching, latency counter and completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNTW{1'b0}};
      last_r  <= 1'b1;
      op_r    <= OP_ADD;
      sel_r   <= 1'b0;
      tag_r   <= {TAGW{1'b0}};
      ops_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_hs_s) begin
            op_r    <= hs_src_s ? op_e'(req1_op) : op_e'(req0_op);
            tag_r   <= hs_src_s ? req1_tag : req0_tag;
            sel_r   <= hs_src_s;
            last_r  <= hs_src_s;
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_r   <= CNTW'(LAT - 1);
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == {CNTW{1'b0}}) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNTW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            ops_r   <= ops_r + 8'd1;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and status decode directly from the state register.
  assign dp_start   = (state_r == ST_ISSUE);
  assign dp_capture = (state_r == ST_WAIT) && (cnt_r == {CNTW{1'b0}});
  assign rsp_valid  = (state_r == ST_RESP);
  assign busy       = !idle_s;
  assign dp_op      = op_r;
  assign dp_sel     = sel_r;
  assign rsp_src    = sel_r;
  assign rsp_tag    = tag_r;
  assign ops_done   = ops_r;

endmodule

// File: tb/tb_simd_ctrl.sv
// tb_simd_ctrl: scoreboard bench for simd_ctrl. Stimulus process drives the
// requesters; a negedge monitor keeps a transaction-level reference model
// (round-robin pointer, in-flight operation, expected event cycles) and a
// queue of expected responses popped whenever the DUT completes a response.
module tb_simd_ctrl;

  localparam int LAT  = 2;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [1:0]      vld;
  logic [1:0]      opv  [2];
  logic [TAGW-1:0] tagv [2];
  logic            req0_ready, req1_ready;
  logic            dp_start, dp_sel, dp_capture;
  logic [1:0]      dp_op;
  logic            rsp_valid, rsp_src, rsp_ready, busy;
  logic [TAGW-1:0] rsp_tag;
  logic [7:0]      ops_done;

  simd_ctrl #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req0_valid (vld[0]),
    .req0_op    (opv[0]),
    .req0_tag   (tagv[0]),
    .req0_ready (req0_ready),
    .req1_valid (vld[1]),
    .req1_op    (opv[1]),
    .req1_tag   (tagv[1]),
    .req1_ready (req1_ready),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .dp_sel     (dp_sel),
    .dp_capture (dp_capture),
    .rsp_valid  (rsp_valid),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            src;
    logic [TAGW-1:0] tag;
    logic [1:0]      op;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_rsp = 0;

  // reference model state
  logic       m_idle = 1'b1;
  logic       m_last = 1'b1;
  logic [7:0] m_ops = 8'd0;
  logic [1:0] m_op = 2'd0;
  logic       m_sel = 1'b0;
  int         exp_start = -1, exp_cap = -1, exp_rsp = -1;

  // stimulus controls
  logic [1:0] hs_seen = 2'b00;
  logic [1:0] auto_req = 2'b00;
  logic       fixed_tag = 1'b0;
  logic       rand_mode = 1'b0;
  logic       gap_mon = 1'b0;
  int         low_run = 0, max_low = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor + reference model + scoreboard, evaluated at the falling edge.
  always @(negedge clk) begin
    logic [1:0] er;
    logic       g;
    exp_t       e;
    cyc++;
    hs_seen = {vld[1] & req1_ready, vld[0] & req0_ready};
    if (!rst) begin
      chk("reset_outputs", {req0_ready, req1_ready, dp_start, dp_op, dp_sel, dp_capture,
                            rsp_valid, rsp_src, rsp_tag, busy, ops_done}, 32'd0);
      m_idle = 1'b1; m_last = 1'b1; m_ops = 8'd0; m_op = 2'd0; m_sel = 1'b0;
      q.delete();
    end else begin
      er = 2'b00;
      g  = 1'b0;
      if (m_idle && enable && (vld != 2'b00)) begin
        g = (vld == 2'b11) ? !m_last : vld[1];
        er[g] = 1'b1;
      end
      chk("req0_ready", req0_ready, er[0]);
      chk("req1_ready", req1_ready, er[1]);
      chk("dp_start", dp_start, !m_idle && cyc == exp_start);
      chk("dp_capture", dp_capture, !m_idle && cyc == exp_cap);
      chk("rsp_valid", rsp_valid, !m_idle && cyc >= exp_rsp);
      chk("busy", busy, !m_idle);
      chk("dp_op", dp_op, m_op);
      chk("dp_sel", dp_sel, m_sel);
      chk("ops_done", ops_done, m_ops);
      if (!m_idle && cyc >= exp_rsp && q.size() > 0) begin
        chk("rsp_src_stable", rsp_src, q[0].src);
        chk("rsp_tag_stable", rsp_tag, q[0].tag);
      end
      if (er != 2'b00) begin
        q.push_back('{src: g, tag: tagv[g], op: opv[g]});
        m_idle = 1'b0; m_last = g; m_op = opv[g]; m_sel = g;
        exp_start = cyc + 1; exp_cap = cyc + 1 + LAT; exp_rsp = cyc + 2 + LAT;
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_src", rsp_src, e.src);
          chk("rsp_tag", rsp_tag, e.tag);
          m_ops = m_ops + 8'd1;
          m_idle = 1'b1;
        end
      end
      if (gap_mon) begin
        if (!busy) low_run++;
        else begin
          if (low_run > max_low) max_low = low_run;
          low_run = 0;
        end
      end
    end
  end

  task automatic new_req(input int p);
    vld[p]  = 1'b1;
    opv[p]  = 2'($urandom_range(0, 3));
    tagv[p] = fixed_tag ? ((p == 1) ? 4'hB : 4'hA) : TAGW'($urandom_range(0, 15));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (hs_seen[p]) begin
        if (auto_req[p]) new_req(p);
        else vld[p] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int p = 0; p < 2; p++) begin
        if (!vld[p]) begin
          if ($urandom_range(0, 2) == 0) new_req(p);
        end else if ($urandom_range(0, 7) == 0) begin
          vld[p] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && vld == 2'b00) break;
      step();
    end
    chk("idle_timeout", {30'd0, busy, |vld}, 32'd0);
  endtask

  initial begin
    logic [7:0] ops_before;
    int base;
    rst = 1'b0; enable = 1'b1; vld = 2'b00; rsp_ready = 1'b1;
    opv[0] = 2'd0; opv[1] = 2'd0; tagv[0] = '0; tagv[1] = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // single request: ADD, tag 5 from requester 0
    opv[0] = 2'd0; tagv[0] = 4'd5; vld[0] = 1'b1;
    repeat (10) step();
    chk("single_ops_done", ops_done, 32'd1);

    // contention with fixed tags, four responses in 4*(LAT+3) cycles
    fixed_tag = 1'b1; auto_req = 2'b11;
    new_req(0); new_req(1);
    base = n_rsp;
    repeat (4 * (LAT + 3)) step();
    chk("contention_rsp_count", n_rsp - base, 32'd4);
    auto_req = 2'b00; vld = 2'b00; fixed_tag = 1'b0;
    wait_idle();

    // backpressure: response held 10 cycles while requester 0 waits
    rsp_ready = 1'b0;
    opv[1] = 2'd2; tagv[1] = 4'd7; vld[1] = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("bp_rsp_seen", rsp_valid, 32'd1);
    new_req(0);
    repeat (10) step();
    ops_before = ops_done;
    rsp_ready = 1'b1;
    step();
    chk("bp_ops_once", ops_done, 32'(ops_before + 8'd1));
    wait_idle();

    // enable gating
    enable = 1'b0;
    opv[1] = 2'd1; tagv[1] = 4'd3; vld[1] = 1'b1;
    repeat (20) step();
    chk("gated_no_ready", req1_ready, 32'd0);
    enable = 1'b1;
    #1;
    chk("enable_same_cycle_ready", req1_ready, 32'd1);
    wait_idle();

    // reset one cycle after dp_start
    new_req(1);
    for (int i = 0; i < 10 && !dp_start; i++) step();
    chk("mid_reset_start_seen", dp_start, 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("mid_reset_immediate", {req0_ready, req1_ready, dp_start, dp_op, dp_sel, dp_capture,
                                rsp_valid, rsp_src, rsp_tag, busy, ops_done}, 32'd0);
    repeat (4) step();
    rst = 1'b1;
    new_req(0); new_req(1);
    #1;
    chk("post_reset_grant0", {req1_ready, req0_ready}, 32'd1);
    wait_idle();

    // randomized traffic, enable and backpressure
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0; enable = 1'b1; rsp_ready = 1'b1; vld = 2'b00;
    wait_idle();

    // counter wrap: 256 back-to-back operations from reset
    step(); rst = 1'b0; step(); rst = 1'b1;
    auto_req = 2'b11;
    new_req(0); new_req(1);
    base = n_rsp;
    step();
    gap_mon = 1'b1;
    for (int i = 0; i < 2500 && (n_rsp - base) < 256; i++) step();
    auto_req = 2'b00; vld = 2'b00; gap_mon = 1'b0;
    chk("wrap_rsp_count", n_rsp - base, 32'd256);
    chk("wrap_ops_done", ops_done, 32'd0);
    chk("wrap_max_idle_gap", max_low, 32'd1);
    wait_idle();
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
